glyph_plotter: RTL and testbench
================================

Name: glyph_plotter

Overview:
- Pixel-stream source for the `vga` display wrapper. It issues the `x`/`y`/`colour`/`plot` writes that `vga` consumes.
- On `start` it reads a W×H monochrome glyph bitmap, one row per word, from a synchronous ROM, then emits one plot per pixel in raster order.
- `pos` is latched and forwarded, so `vga` applies the on-screen cell offset.
- Sits between the control FSM / character-memory reader and `vga`.

Parameters:
- GLYPH_W, 5, glyph width in pixels (bits per ROM word); 1..8
- GLYPH_H, 7, glyph height in rows (ROM words per glyph); 1..16
- ADDR_W, 10, ROM address width

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to draw one glyph; sampled only in IDLE
- clear  in  1  sampled with start; 1 = draw every pixel with colour 0 (erase cell)
- glyph  in  8  glyph index to draw; sampled with start
- pos  in  8  screen cell index; sampled with start
- rom_addr  out  ADDR_W  ROM word address, = glyph*GLYPH_H + row, truncated to ADDR_W
- rom_data  in  GLYPH_W  ROM row word; valid 1 cycle after rom_addr (registered ROM); MSB = leftmost pixel
- x  out  8  pixel column within glyph, 0..GLYPH_W-1
- y  out  7  pixel row within glyph, 0..GLYPH_H-1
- pos_out  out  8  latched pos, constant for the whole glyph
- colour  out  1  pixel value
- plot  out  1  pixel write strobe to `vga`, one pixel per high cycle
- busy  out  1  high from the cycle after start is accepted until the last plot
- done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE.
  - x, y, pos_out, rom_addr, colour, plot, busy, done all 0.
  - Internal row, column and latch registers cleared.
- States: IDLE, FETCH, WAIT, DRAW, DONE.
- IDLE:
  - busy=0, plot=0.
  - On start=1: latch glyph, pos, clear; row=0; go to FETCH.
- FETCH:
  - rom_addr = glyph_l*GLYPH_H + row, registered on entry and held stable through WAIT.
  - Go to WAIT.
- WAIT:
  - Capture rom_data into the row shift register at the end of the cycle.
  - col=0; go to DRAW.
- DRAW, one cycle per pixel:
  - plot=1, x=col, y=row.
  - colour = clear_l ? 0 : rowbits[GLYPH_W-1-col].
  - If col<GLYPH_W-1: col+1.
  - Else if row<GLYPH_H-1: row+1, go to FETCH.
  - Else go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, plot=0; go to IDLE.
- busy=1 in FETCH, WAIT and DRAW only.
- Outputs x/y/colour/plot are registered; they change only on clock edges and are glitch-free to `vga`.
- Timing:
  - Busy lasts exactly GLYPH_H*(GLYPH_W+2) cycles (49 at defaults).
  - done follows the last plot cycle directly.
  - The next start is accepted in IDLE, i.e. the cycle after done, giving a back-to-back period of GLYPH_H*(GLYPH_W+2)+2 cycles.
- plot is 0 in FETCH/WAIT; x/y/colour hold their last values there and are don't-care to `vga` (plot=0).
- start while not IDLE (including in DONE) is ignored; there is no queuing.
- glyph, pos and clear changes after acceptance have no effect until the next start.
- rom_addr arithmetic:
  - Computed at ADDR_W+4 bits internally, then truncated.
  - Wrap-around beyond 2^ADDR_W is silent and permitted.
- Reset asserted mid-glyph returns to IDLE at that edge; plot and busy are 0 in the next cycle, and no done pulse is issued.
- start and reset high together: reset wins, start is discarded.

Test Plan:
1. **Reset:** hold reset 3 cycles with start=1 -> all outputs 0, state IDLE; release -> no activity until a new start.
2. **Single glyph:** start with glyph=2, pos=7, clear=0; ROM returns 5'b10001 for all rows.
   - rom_addr steps 14..20.
   - Exactly 35 plot cycles with x=0..4, y=0..6, colour pattern 1,0,0,0,1 per row.
   - pos_out=7; busy high 49 cycles; done one pulse directly after the last plot.
3. **Clear:** same as 2 with clear=1 -> 35 plots all colour=0; ROM addresses still issued 14..20.
4. **Ignored start:** pulse start with glyph=9 at cycle 10 of an active glyph -> no change to rom_addr sequence, pos_out or plot count.
   - A start asserted in the cycle after done is accepted; rom_addr=63 one cycle later.
5. **Mid-operation reset:** assert reset during DRAW of row 3 -> next cycle plot=0, busy=0, done never pulses.
   - A fresh start redraws from row 0.
6. **Address wrap:** ADDR_W=6, glyph=10 -> rom_addr = (70+row) mod 64, i.e. 6..12, and drawing completes normally.

Source files
------------

// File: rtl/glyph_plotter_if.sv
// Glyph plotter bus: draw request from the control side, ROM port, and pixel writes to vga.
// Directions are from the plotter's point of view in the slave modport.
interface glyph_plotter_if #(
    parameter int GLYPH_W = 5,
    parameter int ADDR_W  = 10
);
    logic                start;
    logic                clear;
    logic [7:0]          glyph;
    logic [7:0]          pos;
    logic [ADDR_W-1:0]   rom_addr;
    logic [GLYPH_W-1:0]  rom_data;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [7:0]          pos_out;
    logic                colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport slave (
        input  start, clear, glyph, pos, rom_data,
        output rom_addr, x, y, pos_out, colour, plot, busy, done
    );

    modport master (
        output start, clear, glyph, pos, rom_data,
        input  rom_addr, x, y, pos_out, colour, plot, busy, done
    );
endinterface

// File: rtl/glyph_plotter.sv
// Purpose: fetch a GLYPH_W x GLYPH_H bitmap row by row from a registered ROM and emit one plot per pixel.
// Latency: first plot 3 cycles after start; busy for GLYPH_H*(GLYPH_W+2) cycles, then a 1-cycle done.
// Backpressure: none; start is accepted only in IDLE and dropped otherwise.
module glyph_plotter #(
    parameter int GLYPH_W = 5,
    parameter int GLYPH_H = 7,
    parameter int ADDR_W  = 10
) (
    input  logic          clock,
    input  logic          reset,
    glyph_plotter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, DONE} state_t;

    localparam int         FULL_W   = ADDR_W + 4;
    localparam logic [7:0] LAST_COL = 8'(GLYPH_W - 1);
    localparam logic [6:0] LAST_ROW = 7'(GLYPH_H - 1);

    state_t              state, state_n;
    logic [7:0]          glyph_l, glyph_n;
    logic [7:0]          pos_l, pos_n;
    logic                clear_l, clear_n;
    logic [6:0]          row, row_n;
    logic [GLYPH_W-1:0]  bits, bits_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [7:0]          x_q, x_n;
    logic [6:0]          y_q, y_n;
    logic                colour_q, colour_n;
    logic                plot_q, busy_q, done_q;
    logic [FULL_W-1:0]   addr_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            glyph_l  <= '0;
            pos_l    <= '0;
            clear_l  <= 1'b0;
            row      <= '0;
            bits     <= '0;
            addr_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= 1'b0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            glyph_l  <= glyph_n;
            pos_l    <= pos_n;
            clear_l  <= clear_n;
            row      <= row_n;
            bits     <= bits_n;
            addr_q   <= addr_n;
            x_q      <= x_n;
            y_q      <= y_n;
            colour_q <= colour_n;
            // Strobes are registered from the next state so they align exactly with it.
            plot_q   <= (state_n == DRAW);
            busy_q   <= (state_n == FETCH) || (state_n == WAIT) || (state_n == DRAW);
            done_q   <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n  = state;
        glyph_n  = glyph_l;
        pos_n    = pos_l;
        clear_n  = clear_l;
        row_n    = row;
        bits_n   = bits;
        x_n      = x_q;
        y_n      = y_q;
        colour_n = colour_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    glyph_n = bus.glyph;
                    pos_n   = bus.pos;
                    clear_n = bus.clear;
                    row_n   = '0;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = WAIT;
            WAIT: begin
                // The leftmost pixel goes straight out; the rest are shifted out of bits.
                x_n      = '0;
                y_n      = row;
                colour_n = ~clear_l & bus.rom_data[GLYPH_W-1];
                bits_n   = bus.rom_data << 1;
                state_n  = DRAW;
            end
            DRAW: begin
                if (x_q < LAST_COL) begin
                    x_n      = x_q + 8'd1;
                    colour_n = ~clear_l & bits[GLYPH_W-1];
                    bits_n   = bits << 1;
                end else if (row < LAST_ROW) begin
                    row_n   = row + 7'd1;
                    state_n = FETCH;
                end else begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Wide intermediate, then silent truncation: high glyph indices wrap the ROM.
        addr_full = FULL_W'(glyph_n) * FULL_W'(GLYPH_H) + FULL_W'(row_n);
        addr_n    = (state_n == FETCH) ? addr_full[ADDR_W-1:0] : addr_q;
    end

    assign bus.rom_addr = addr_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.pos_out  = pos_l;
    assign bus.colour   = colour_q;
    assign bus.plot     = plot_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_glyph_plotter.sv
// Bench for glyph_plotter: a 10-bit and a 6-bit address instance run in lockstep against a per-cycle trace model.
module tb_glyph_plotter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    glyph_plotter_if #(.GLYPH_W(5), .ADDR_W(10)) bus0 ();
    glyph_plotter_if #(.GLYPH_W(5), .ADDR_W(6))  bus1 ();

    glyph_plotter #(.GLYPH_W(5), .GLYPH_H(7), .ADDR_W(10)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    glyph_plotter #(.GLYPH_W(5), .GLYPH_H(7), .ADDR_W(6))  dut1 (.clock(clock), .reset(reset), .bus(bus1));

    assign bus1.start = bus0.start;
    assign bus1.clear = bus0.clear;
    assign bus1.glyph = bus0.glyph;
    assign bus1.pos   = bus0.pos;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int rom_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ROM contents depend only on the low 6 address bits so both instances read the same data.
    function automatic logic [4:0] rom_fn(input logic [5:0] a);
        logic [7:0] t;
        t = {2'b00, a} * 8'd5 + 8'd3;
        if (rom_mode == 0) return 5'b10001;
        return t[4:0];
    endfunction

    always @(posedge clock) begin
        bus0.rom_data <= rom_fn(bus0.rom_addr[5:0]);
        bus1.rom_data <= rom_fn(bus1.rom_addr);
    end

    typedef struct {
        bit         busy;
        bit         plot;
        bit         done;
        bit         av;
        logic [13:0] addr;
        logic [7:0] x;
        logic [6:0] y;
        bit         colour;
        logic [7:0] pos;
    } ent_t;

    ent_t exp_q[$];
    ent_t cur;

    // Expected per-cycle trace of one glyph: per row a fetch cycle, a wait cycle, then one cycle per pixel.
    function automatic void push_glyph(input logic [7:0] g, input logic [7:0] p, input logic c);
        ent_t en;
        logic [4:0] d;
        int a;
        for (int r = 0; r < 7; r++) begin
            a = g * 7 + r;
            d = rom_fn(6'(a));
            en = '{default: 0};
            en.busy = 1; en.av = 1; en.addr = 14'(a); en.pos = p;
            exp_q.push_back(en);
            exp_q.push_back(en);
            for (int cx = 0; cx < 5; cx++) begin
                en.av = 0; en.plot = 1;
                en.x = 8'(cx); en.y = 7'(r);
                en.colour = c ? 1'b0 : d[4-cx];
                exp_q.push_back(en);
            end
        end
        en = '{default: 0};
        en.done = 1;
        exp_q.push_back(en);
    endfunction

    always @(posedge clock) begin
        bit was_idle;
        was_idle = (exp_q.size() == 0);
        if (!was_idle) void'(exp_q.pop_front());
        if (reset) exp_q.delete();
        else if (was_idle && bus0.start) push_glyph(bus0.glyph, bus0.pos, bus0.clear);
    end

    always @(negedge clock) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cur = exp_q[0];
            else cur = '{default: 0};
            chk("busy0", bus0.busy, cur.busy);
            chk("plot0", bus0.plot, cur.plot);
            chk("done0", bus0.done, cur.done);
            chk("busy1", bus1.busy, cur.busy);
            chk("plot1", bus1.plot, cur.plot);
            chk("done1", bus1.done, cur.done);
            if (cur.av) begin
                chk("rom_addr0", bus0.rom_addr, 32'(cur.addr[9:0]));
                chk("rom_addr1", bus1.rom_addr, 32'(cur.addr[5:0]));
            end
            if (cur.plot) begin
                chk("x0", bus0.x, cur.x);
                chk("y0", bus0.y, cur.y);
                chk("colour0", bus0.colour, cur.colour);
                chk("x1", bus1.x, cur.x);
                chk("colour1", bus1.colour, cur.colour);
            end
            if (cur.busy) chk("pos_out0", bus0.pos_out, cur.pos);
        end
    end

    int busy_cnt, plot_cnt, ones0, ones1;
    int first0, last0, first1, last1, pos_seen;
    bit seen, done_after_plot;

    task automatic run_glyph(input logic [7:0] g, input logic [7:0] p, input logic c, input int inj);
        bit prev_plot;
        @(posedge clock); #2;
        bus0.start = 1'b1; bus0.glyph = g; bus0.pos = p; bus0.clear = c;
        @(posedge clock); #2;
        bus0.start = 1'b0;
        busy_cnt = 0; plot_cnt = 0; ones0 = 0; ones1 = 0;
        first0 = -1; last0 = -1; first1 = -1; last1 = -1;
        seen = 0; done_after_plot = 0; prev_plot = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (i == inj) begin bus0.start = 1'b1; bus0.glyph = 8'd9; end
            if (i == inj + 1) bus0.start = 1'b0;
            if (bus0.done) begin seen = 1; done_after_plot = prev_plot; end
            if (bus0.busy) begin
                busy_cnt++;
                if (busy_cnt == 1) begin first0 = int'(bus0.rom_addr); first1 = int'(bus1.rom_addr); end
                if (!bus0.plot) begin last0 = int'(bus0.rom_addr); last1 = int'(bus1.rom_addr); end
                pos_seen = int'(bus0.pos_out);
            end
            if (bus0.plot) plot_cnt++;
            if (bus0.plot && bus0.colour) ones0++;
            if (bus1.plot && bus1.colour) ones1++;
            prev_plot = bus0.plot;
        end
        chk("done_seen", seen, 1);
    endtask

    initial begin
        bit found, done_hit;
        bus0.start = 1'b1; bus0.clear = 1'b0; bus0.glyph = 8'd5; bus0.pos = 8'd3;

        // Reset held with start high.
        reset = 1'b1;
        @(posedge clock); #1 chk_en = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_plot", bus0.plot, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_rom_addr", bus0.rom_addr, 0);
        chk("rst_x", bus0.x, 0);
        chk("rst_y", bus0.y, 0);
        chk("rst_pos_out", bus0.pos_out, 0);
        chk("rst_colour", bus0.colour, 0);
        chk("rst_rom_addr1", bus1.rom_addr, 0);
        bus0.start = 1'b0;
        #1 reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("idle_busy", bus0.busy, 0);

        // Single glyph.
        run_glyph(8'd2, 8'd7, 1'b0, -1);
        chk("t2_first_addr", first0, 14);
        chk("t2_last_addr", last0, 20);
        chk("t2_plots", plot_cnt, 35);
        chk("t2_busy", busy_cnt, 49);
        chk("t2_ones", ones0, 14);
        chk("t2_pos", pos_seen, 7);
        chk("t2_done_follow", done_after_plot, 1);

        // Erase.
        run_glyph(8'd2, 8'd7, 1'b1, -1);
        chk("t3_first_addr", first0, 14);
        chk("t3_last_addr", last0, 20);
        chk("t3_plots", plot_cnt, 35);
        chk("t3_ones", ones0, 0);

        // Start while busy is dropped; start straight after done is taken.
        run_glyph(8'd2, 8'd7, 1'b0, 10);
        chk("t4_first_addr", first0, 14);
        chk("t4_last_addr", last0, 20);
        chk("t4_plots", plot_cnt, 35);
        chk("t4_pos", pos_seen, 7);
        run_glyph(8'd9, 8'd7, 1'b0, -1);
        chk("t4_b2b_addr", first0, 63);

        // Reset in the middle of row 3.
        @(posedge clock); #2;
        bus0.start = 1'b1; bus0.glyph = 8'd3; bus0.pos = 8'd4; bus0.clear = 1'b0;
        @(posedge clock); #2;
        bus0.start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (bus0.plot && bus0.y == 7'd3) found = 1;
        end
        chk("t5_row3", found, 1);
        reset = 1'b1;
        @(posedge clock); #2 reset = 1'b0;
        @(negedge clock);
        chk("t5_plot", bus0.plot, 0);
        chk("t5_busy", bus0.busy, 0);
        done_hit = 0;
        repeat (60) begin
            @(negedge clock);
            if (bus0.done) done_hit = 1;
        end
        chk("t5_no_done", done_hit, 0);
        run_glyph(8'd3, 8'd4, 1'b0, -1);
        chk("t5_redraw_addr", first0, 21);
        chk("t5_redraw_plots", plot_cnt, 35);

        // Address wrap on the 6-bit instance, with varied row data.
        rom_mode = 1;
        run_glyph(8'd10, 8'd20, 1'b0, -1);
        chk("t6_first0", first0, 70);
        chk("t6_last0", last0, 76);
        chk("t6_first1", first1, 6);
        chk("t6_last1", last1, 12);
        chk("t6_plots", plot_cnt, 35);
        chk("t6_busy", busy_cnt, 49);
        chk("t6_ones0", ones0, 18);
        chk("t6_ones1", ones1, 18);

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
